zube_ext_bus_if: RTL and testbench

- External-bus front end of the zube mailbox. Sits between the GPIO pads and the wishbone-side mailbox registers.
- Synchronises an asynchronous 8-bit external CPU bus (chip select, read and write strobes, 2-bit address) into the core clock domain.
- Pushes external writes into an RX FIFO, presented to the mailbox as a valid/ready stream.
- Serves external reads from a one-entry TX holding register and a status byte.

---
 rtl/zube_ext_bus_if.sv | 279 +++++++++++++++++++++++++++
 tb/tb_zube_ext_bus_if.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/zube_ext_bus_if.sv
// ---------------------------------------------------------------------------
// zube_ext_bus_if
// External-bus front end of the zube mailbox. Synchronises an asynchronous
// 8-bit CPU bus into the core clock domain, pushes external writes into an
// RX FIFO (valid/ready stream towards the mailbox) and serves external reads
// from a one-entry TX holding register and a status byte.
//
// Ports
//   clk, reset          core clock, synchronous active-high reset
//   ext_data_in/out/oeb external data bus (pad in, pad out, active-low OE)
//   ext_addr            0 = RX data, 1 = TX data, 2 = status, 3 = reserved
//   ext_cs_b/rd_b/wr_b  asynchronous active-low chip select and strobes
//   ext_irq_b           active-low interrupt (only with ZUBE_EXT_IRQ_EN)
//   rx_data/valid/ready RX FIFO head towards the mailbox
//   tx_data/valid/ready mailbox byte into the TX holding register
//   ovf_pulse           one-cycle pulse when an external write is dropped
//
// Build option: define ZUBE_EXT_IRQ_EN to generate the interrupt output;
// otherwise ext_irq_b is tied high.
// ---------------------------------------------------------------------------
// state       | meaning
// ST_ARM      | after reset, wait for both strobes released
// ST_IDLE     | wait for a qualified read or write strobe
// ST_WR_HOLD  | write done, wait for write strobe release
// ST_RD_DRIVE | driving latched read data onto the pads
// ST_RD_END   | bus released, apply read side effects
// ---------------------------------------------------------------------------
module zube_ext_bus_if #(
   parameter int RX_DEPTH    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] ext_data_in,
   output logic [7:0] ext_data_out,
   output logic [7:0] ext_data_oeb,
   input  logic [1:0] ext_addr,
   input  logic       ext_cs_b,
   input  logic       ext_rd_b,
   input  logic       ext_wr_b,
   output logic       ext_irq_b,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       ovf_pulse
);

   localparam int AW = $clog2(RX_DEPTH);

   // Strobes reset to their asserted level so that a strobe held low across
   // reset still looks active to ARM until the real pin value has propagated.
   localparam logic [12:0] SYNC_RST = {1'b1, 1'b0, 1'b0, 2'b00, 8'h00};

   typedef enum logic [2:0] {
      ST_ARM,
      ST_IDLE,
      ST_WR_HOLD,
      ST_RD_DRIVE,
      ST_RD_END
   } state_t;

   logic [SYNC_STAGES-1:0][12:0] sync_q;
   logic [12:0] sync_out;
   logic        cs, rd, wr;
   logic [1:0]  addr;
   logic [7:0]  din;

   state_t      state_q, state_d;
   logic        push_req, rd_start, rd_finish;

   logic [7:0]  dout_q, oeb_q;
   logic [1:0]  addr_q;
   logic        rd_hit_q;
   logic [7:0]  rd_mux;
   logic        rd_hit, udf_set;

   logic        ovf_q, ovf_d, udf_q, udf_d;
   logic        ovf_pulse_q;
   logic        clr_flags;

   logic [7:0]  tx_q;
   logic        tx_full_q;
   logic        tx_load, tx_clear;

   logic [7:0]  mem [RX_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        rx_full, rx_empty, push_ok, drop, pop;

   // ------------------------------------------------------------------
   // input synchronisers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{SYNC_RST}};
      end else begin
         sync_q[0] <= {ext_cs_b, ext_rd_b, ext_wr_b, ext_addr, ext_data_in};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign cs       = ~sync_out[12];
   assign rd       = ~sync_out[11];
   assign wr       = ~sync_out[10];
   assign addr     = sync_out[9:8];
   assign din      = sync_out[7:0];

   // ------------------------------------------------------------------
   // bus FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_ARM;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      push_req  = 1'b0;
      rd_start  = 1'b0;
      rd_finish = 1'b0;
      case (state_q)
         ST_ARM: begin
            if (!rd && !wr) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (cs && wr && !rd) begin
               state_d  = ST_WR_HOLD;
               push_req = (addr == 2'd0);
            end else if (cs && rd && !wr) begin
               state_d  = ST_RD_DRIVE;
               rd_start = 1'b1;
            end
         end
         ST_WR_HOLD: begin
            if (!wr) state_d = ST_IDLE;
         end
         ST_RD_DRIVE: begin
            if (!rd || !cs) state_d = ST_RD_END;
         end
         ST_RD_END: begin
            rd_finish = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_ARM;
      endcase
   end

   // ------------------------------------------------------------------
   // read mux, sampled when the read is accepted in IDLE
   // ------------------------------------------------------------------
   always_comb begin
      rd_mux  = 8'h00;
      rd_hit  = 1'b0;
      udf_set = 1'b0;
      case (addr)
         2'd1: begin
            if (tx_full_q) begin
               rd_mux = tx_q;
               rd_hit = 1'b1;
            end else begin
               rd_mux  = 8'hFF;
               udf_set = rd_start;
            end
         end
         2'd2:    rd_mux = {4'b0000, udf_q, ovf_q, tx_full_q, rx_full};
         default: rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q   <= 8'h00;
         oeb_q    <= 8'hFF;
         addr_q   <= 2'd0;
         rd_hit_q <= 1'b0;
      end else begin
         oeb_q <= (state_d == ST_RD_DRIVE) ? 8'h00 : 8'hFF;
         if (rd_start) begin
            dout_q   <= rd_mux;
            addr_q   <= addr;
            rd_hit_q <= rd_hit;
         end
      end
   end

   assign ext_data_out = dout_q;
   assign ext_data_oeb = oeb_q;

   // ------------------------------------------------------------------
   // sticky flags; a set in the clearing cycle wins
   // ------------------------------------------------------------------
   assign clr_flags = rd_finish && (addr_q == 2'd2);
   assign ovf_d     = drop    ? 1'b1 : (clr_flags ? 1'b0 : ovf_q);
   assign udf_d     = udf_set ? 1'b1 : (clr_flags ? 1'b0 : udf_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         ovf_pulse_q <= 1'b0;
      end else begin
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         ovf_pulse_q <= drop;
      end
   end

   assign ovf_pulse = ovf_pulse_q;

   // ------------------------------------------------------------------
   // TX holding register
   // ------------------------------------------------------------------
   // Only clear if the read actually returned the held byte; a byte loaded
   // while an underflowing read is still on the bus must survive.
   assign tx_load  = tx_valid && !tx_full_q;
   assign tx_clear = rd_finish && (addr_q == 2'd1) && rd_hit_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_q      <= 8'h00;
         tx_full_q <= 1'b0;
      end else if (tx_load) begin
         tx_q      <= tx_data;
         tx_full_q <= 1'b1;
      end else if (tx_clear) begin
         tx_full_q <= 1'b0;
      end
   end

   assign tx_ready = ~tx_full_q;

   // ------------------------------------------------------------------
   // RX FIFO
   // ------------------------------------------------------------------
   assign rx_empty = (wr_ptr_q == rd_ptr_q);
   assign rx_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // full is judged before any same-cycle pop
   assign push_ok  = push_req && !rx_full;
   assign drop     = push_req && rx_full;
   assign pop      = !rx_empty && rx_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din;
   end

   assign rx_valid = ~rx_empty;
   assign rx_data  = rx_empty ? 8'h00 : mem[rd_ptr_q[AW-1:0]];

   // ------------------------------------------------------------------
   // interrupt
   // ------------------------------------------------------------------
`ifdef ZUBE_EXT_IRQ_EN
   logic irq_b_q;
   always_ff @(posedge clk) begin
      if (reset) irq_b_q <= 1'b1;
      else       irq_b_q <= ~(tx_full_q || ovf_q);
   end
   assign ext_irq_b = irq_b_q;
`else
   assign ext_irq_b = 1'b1;
`endif

endmodule

// File: tb/tb_zube_ext_bus_if.sv
module tb_zube_ext_bus_if;

`ifdef ZUBE_EXT_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] ext_data_in;
   logic [7:0] ext_data_out;
   logic [7:0] ext_data_oeb;
   logic [1:0] ext_addr;
   logic       ext_cs_b, ext_rd_b, ext_wr_b;
   logic       ext_irq_b;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic       ovf_pulse;

   int checks   = 0;
   int failures = 0;
   int ovf_cycles = 0;
   bit log_en = 1'b0;
   logic [7:0] pop_log[$];

   zube_ext_bus_if #(.RX_DEPTH(8), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .ext_data_in  (ext_data_in),
      .ext_data_out (ext_data_out),
      .ext_data_oeb (ext_data_oeb),
      .ext_addr     (ext_addr),
      .ext_cs_b     (ext_cs_b),
      .ext_rd_b     (ext_rd_b),
      .ext_wr_b     (ext_wr_b),
      .ext_irq_b    (ext_irq_b),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .ovf_pulse    (ovf_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ovf_pulse) ovf_cycles <= ovf_cycles + 1;
      if (log_en && rx_valid && rx_ready) pop_log.push_back(rx_data);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic ext_write(input logic [1:0] a, input logic [7:0] d);
      ext_cs_b    = 1'b0;
      ext_addr    = a;
      ext_data_in = d;
      cyc(2);
      ext_wr_b = 1'b0;
      cyc(5);
      ext_wr_b = 1'b1;
      cyc(5);
      ext_cs_b = 1'b1;
      cyc(1);
   endtask

   task automatic ext_read(input logic [1:0] a, input logic [7:0] exp, input string tag);
      ext_cs_b = 1'b0;
      ext_addr = a;
      cyc(2);
      ext_rd_b = 1'b0;
      cyc(6);
      chk({tag, "_oeb_drive"}, ext_data_oeb, 8'h00);
      chk({tag, "_data"}, ext_data_out, exp);
      ext_rd_b = 1'b1;
      cyc(6);
      chk({tag, "_oeb_release"}, ext_data_oeb, 8'hFF);
      ext_cs_b = 1'b1;
      cyc(2);
   endtask

   task automatic pop1;
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
   endtask

   initial begin
      int ovf_base;
      reset       = 1'b1;
      ext_cs_b    = 1'b0;
      ext_rd_b    = 1'b1;
      ext_wr_b    = 1'b0;
      ext_addr    = 2'd0;
      ext_data_in = 8'h77;
      rx_ready    = 1'b0;
      tx_data     = 8'h00;
      tx_valid    = 1'b0;
      cyc(3);

      // reset values
      chk("rst_oeb", ext_data_oeb, 8'hFF);
      chk("rst_dout", ext_data_out, 8'h00);
      chk("rst_irq", {7'd0, ext_irq_b}, 8'h01);
      chk("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_tx_ready", {7'd0, tx_ready}, 8'h01);
      chk("rst_ovf_pulse", {7'd0, ovf_pulse}, 8'h00);

      // write strobe held low across reset must not push
      reset = 1'b0;
      cyc(10);
      ext_wr_b = 1'b1;
      cyc(6);
      ext_cs_b = 1'b1;
      cyc(2);
      chk("arm_no_push", {7'd0, rx_valid}, 8'h00);

      ext_write(2'd0, 8'hA5);
      chk("wr_a5_data", rx_data, 8'hA5);
      chk("wr_a5_valid", {7'd0, rx_valid}, 8'h01);
      pop1();
      chk("pop_a5_empty", {7'd0, rx_valid}, 8'h00);

      // fill FIFO and overflow
      ovf_base = ovf_cycles;
      for (int i = 1; i <= 8; i++) ext_write(2'd0, 8'(i));
      ext_write(2'd1, 8'hEE);
      chk("full_no_ovf", 8'(ovf_cycles - ovf_base), 8'h00);
      ext_read(2'd2, 8'h01, "stat_full");
      ext_write(2'd0, 8'h09);
      chk("ovf_one_pulse", 8'(ovf_cycles - ovf_base), 8'h01);
      cyc(2);
      chk("ovf_irq", {7'd0, ext_irq_b}, IRQ_EN ? 8'h00 : 8'h01);
      ext_read(2'd2, 8'h05, "stat_ovf");
      ext_read(2'd2, 8'h01, "stat_ovf_clr");
      cyc(2);
      chk("ovf_irq_clr", {7'd0, ext_irq_b}, 8'h01);
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("fifo_order_%0d", i), rx_data, 8'(i));
         pop1();
      end
      chk("fifo_drained", {7'd0, rx_valid}, 8'h00);

      // TX holding register
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      cyc(1);
      tx_valid = 1'b0;
      chk("tx_loaded_ready", {7'd0, tx_ready}, 8'h00);
      cyc(2);
      chk("tx_irq", {7'd0, ext_irq_b}, IRQ_EN ? 8'h00 : 8'h01);
      ext_read(2'd1, 8'h3C, "tx_rd");
      chk("tx_ready_back", {7'd0, tx_ready}, 8'h01);
      chk("tx_irq_clr", {7'd0, ext_irq_b}, 8'h01);
      ext_read(2'd1, 8'hFF, "tx_udf");
      ext_read(2'd2, 8'h08, "stat_udf");
      ext_read(2'd2, 8'h00, "stat_udf_clr");
      ext_read(2'd3, 8'h00, "rsvd");

      // FIFO wrap with continuous popping
      ovf_base = ovf_cycles;
      log_en   = 1'b1;
      rx_ready = 1'b1;
      for (int i = 0; i < 20; i++) ext_write(2'd0, 8'h40 + 8'(i));
      cyc(2);
      rx_ready = 1'b0;
      log_en   = 1'b0;
      chk("wrap_count", 8'(pop_log.size()), 8'd20);
      for (int i = 0; i < 20; i++) begin
         if (i < pop_log.size()) chk($sformatf("wrap_%0d", i), pop_log[i], 8'h40 + 8'(i));
      end
      chk("wrap_no_ovf", 8'(ovf_cycles - ovf_base), 8'h00);
      ext_read(2'd2, 8'h00, "stat_wrap");

      // reset during RD_DRIVE
      ext_write(2'd0, 8'h11);
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      cyc(1);
      tx_valid = 1'b0;
      ext_cs_b = 1'b0;
      ext_addr = 2'd1;
      cyc(2);
      ext_rd_b = 1'b0;
      cyc(6);
      chk("mid_oeb_drive", ext_data_oeb, 8'h00);
      reset = 1'b1;
      cyc(1);
      chk("mid_rst_oeb", ext_data_oeb, 8'hFF);
      chk("mid_rst_tx_ready", {7'd0, tx_ready}, 8'h01);
      chk("mid_rst_rx_valid", {7'd0, rx_valid}, 8'h00);
      cyc(2);
      reset = 1'b0;
      cyc(10);
      chk("mid_arm_hold", ext_data_oeb, 8'hFF);
      ext_rd_b = 1'b1;
      cyc(6);
      ext_cs_b = 1'b1;
      cyc(2);
      ext_read(2'd2, 8'h00, "mid_stat");
      ext_write(2'd0, 8'hC3);
      chk("mid_wr_data", rx_data, 8'hC3);
      chk("mid_wr_valid", {7'd0, rx_valid}, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
